rmw_sweep_driver: RTL and testbench

Initiator-side sequencer for the 8-entry, 32-bit read/conditional-write memory used in the delay test designs. On a start command it walks a contiguous, wrapping address range and issues one memory command per cycle: either increment (enable high) or copy-from-address+4 (enable low). It samples the combinational read data on every issued cycle. It sits between test/control logic and the memory, and owns the enable/address side of that interface.

---
 rtl/rmw_sweep_driver_pkg.sv | 23 ++
 rtl/rmw_sweep_addr_gen.sv | 57 +++++
 rtl/rmw_sweep_driver.sv | 135 +++++++++++++
 tb/tb_rmw_sweep_driver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rmw_sweep_driver_pkg.sv
// Shared definitions for the RMW sweep driver: default sizes, the memory
// command encoding and the sequencer state type.
package rmw_sweep_driver_pkg;

  // Default geometry of the read/conditional-write memory.
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  // Command encoding. It is carried on the memory enable line.
  typedef enum logic {
    OP_COPY = 1'b0,  // mem[a] <= mem[a+4]
    OP_INC  = 1'b1   // mem[a] <= mem[a] + 1
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : rmw_sweep_driver_pkg

// File: rtl/rmw_sweep_addr_gen.sv
// Address generator for the RMW sweep. It holds the base and length latched
// at start, counts the command index and produces the word address that wraps
// modulo DEPTH. It also flags the final command. A length above DEPTH is
// clamped to DEPTH when it is latched.
module rmw_sweep_addr_gen
  import rmw_sweep_driver_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     step,
  input  logic [$clog2(DEPTH)-1:0] base,
  input  logic [$clog2(DEPTH):0]   len,
  output logic [$clog2(DEPTH)-1:0] addr,
  output logic                     last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] base_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] idx_q;
  logic [CW-1:0] len_clamped;

  // Clamp the requested length so that a sweep never revisits a word.
  always_comb begin
    len_clamped = (len > CW'(DEPTH)) ? CW'(DEPTH) : len;
  end

  // Latch the sweep parameters at start, then advance one index per command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state always uses non-blocking assignments, so every
      // register samples the values that were present before the clock edge.
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else if (load) begin
      base_q <= base;
      len_q  <= len_clamped;
      idx_q  <= '0;
    end else if (step) begin
      idx_q <= idx_q + CW'(1);
    end
  end

  // Address wrap comes free because the sum is truncated to AW bits (DEPTH is
  // a power of two).
  always_comb begin
    addr = base_q + idx_q[AW-1:0];
    last = (idx_q == (len_q - CW'(1)));
  end

endmodule : rmw_sweep_addr_gen

// File: rtl/rmw_sweep_driver.sv
// Initiator-side sequencer for the 8-entry read/conditional-write memory.
// On start it walks a contiguous, wrapping address range. It issues one INC
// or COPY command per cycle and samples the combinational read data of each
// command it issues.
//
// The memory-side outputs are registered copies of the internal state. The
// command that the FSM issues in internal cycle k is therefore presented to
// the memory in cycle k+1. io_done and io_busy follow the same one-cycle lag.
//
// Optional feature macro: RMW_SWEEP_SUM_EN. When it is defined, io_sum is a
// running sum of the sampled read data. When it is not defined, io_sum is
// tied to 0.
module rmw_sweep_driver
  import rmw_sweep_driver_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_start,
  input  logic                     io_op,
  input  logic [$clog2(DEPTH)-1:0] io_base,
  input  logic [$clog2(DEPTH):0]   io_len,
  output logic                     io_busy,
  output logic                     io_done,
  output logic                     io_mem_valid,
  output logic                     io_mem_enable,
  output logic [ADDR_W-1:0]        io_mem_addr,
  input  logic [DATA_W-1:0]        io_mem_rdata,
  output logic [DATA_W-1:0]        io_sum,
  output logic [DATA_W-1:0]        io_last
);

  localparam int AW = $clog2(DEPTH);

  state_e        state;
  state_e        state_next;
  op_e           op_q;
  logic          gen_load;
  logic          gen_step;
  logic          gen_last;
  logic [AW-1:0] gen_addr;

  rmw_sweep_addr_gen #(
    .DEPTH(DEPTH)
  ) u_addr_gen (
    .clk  (clk),
    .reset(reset),
    .load (gen_load),
    .step (gen_step),
    .base (io_base),
    .len  (io_len),
    .addr (gen_addr),
    .last (gen_last)
  );

  // State register. Reset aborts any sweep that is in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and sweep control strobes. A start is honoured only in IDLE.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves a
    // value unassigned and no latch is inferred.
    state_next = state;
    gen_load   = 1'b0;
    gen_step   = 1'b0;
    unique case (state)
      IDLE: begin
        if (io_start) begin
          gen_load   = 1'b1;
          state_next = (io_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        gen_step = 1'b1;
        if (gen_last) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the command type for the whole sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         op_q <= OP_COPY;
    else if (gen_load) op_q <= op_e'(io_op);
  end

  // Registered memory command and status outputs. The command fields are
  // zero in every state except ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_mem_valid  <= 1'b0;
      io_mem_enable <= 1'b0;
      io_mem_addr   <= '0;
      io_busy       <= 1'b0;
      io_done       <= 1'b0;
    end else begin
      io_mem_valid  <= (state == ISSUE);
      io_mem_enable <= (state == ISSUE) && (op_q == OP_INC);
      io_mem_addr   <= (state == ISSUE) ? ADDR_W'(gen_addr) : '0;
      io_busy       <= (state != IDLE);
      io_done       <= (state == DONE);
    end
  end

  // Capture the read data of each command while that command is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             io_last <= '0;
    else if (io_mem_valid) io_last <= io_mem_rdata;
  end

`ifdef RMW_SWEEP_SUM_EN
  // Running sum of the sampled read data. It is cleared by each accepted
  // start and wraps at DATA_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             io_sum <= '0;
    else if (gen_load)     io_sum <= '0;
    else if (io_mem_valid) io_sum <= io_sum + io_mem_rdata;
  end
`else
  // This build has no accumulator.
  assign io_sum = '0;
`endif

endmodule : rmw_sweep_driver

// File: tb/tb_rmw_sweep_driver.sv
// Self-checking directed bench for rmw_sweep_driver. A behavioural 8x32 memory
// model executes the INC/COPY commands. Expected io_sum values depend on
// whether RMW_SWEEP_SUM_EN is defined.
module tb_rmw_sweep_driver;

`ifdef RMW_SWEEP_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        io_start;
  logic        io_op;
  logic [2:0]  io_base;
  logic [3:0]  io_len;
  logic        io_busy;
  logic        io_done;
  logic        io_mem_valid;
  logic        io_mem_enable;
  logic [31:0] io_mem_addr;
  logic [31:0] io_mem_rdata;
  logic [31:0] io_sum;
  logic [31:0] io_last;

  logic [31:0] mem      [0:7];
  logic [31:0] mem_init [0:7];
  logic        mem_load;

  // Per-cycle log of one sweep; index c is the c-th cycle after the start edge.
  logic        lv [1:31];
  logic        le [1:31];
  logic        ld [1:31];
  logic        lb [1:31];
  logic [31:0] la [1:31];

  int checks   = 0;
  int failures = 0;

  rmw_sweep_driver dut (
    .clk          (clk),
    .reset        (reset),
    .io_start     (io_start),
    .io_op        (io_op),
    .io_base      (io_base),
    .io_len       (io_len),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .io_mem_valid (io_mem_valid),
    .io_mem_enable(io_mem_enable),
    .io_mem_addr  (io_mem_addr),
    .io_mem_rdata (io_mem_rdata),
    .io_sum       (io_sum),
    .io_last      (io_last)
  );

  always #5 clk = ~clk;

  // Memory model: the read is combinational. A command is executed on the edge
  // that ends the cycle in which it is presented.
  assign io_mem_rdata = mem[io_mem_addr[2:0]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 8; i++) mem[i] <= mem_init[i];
    end else if (io_mem_valid) begin
      if (io_mem_enable) mem[io_mem_addr[2:0]] <= mem[io_mem_addr[2:0]] + 32'd1;
      else               mem[io_mem_addr[2:0]] <= mem[io_mem_addr[2:0] + 3'd4];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3,
                         input logic [31:0] v4, input logic [31:0] v5,
                         input logic [31:0] v6, input logic [31:0] v7);
    mem_init[0] = v0; mem_init[1] = v1; mem_init[2] = v2; mem_init[3] = v3;
    mem_init[4] = v4; mem_init[5] = v5; mem_init[6] = v6; mem_init[7] = v7;
    mem_load = 1'b1;
    @(posedge clk); #1;
    mem_load = 1'b0;
  endtask

  // Request a start and log ncyc cycles. With hold set, io_start stays high
  // for the whole window.
  task automatic run_sweep(input logic op, input logic [2:0] base, input logic [3:0] len,
                           input int ncyc, input bit hold);
    io_op    = op;
    io_base  = base;
    io_len   = len;
    io_start = 1'b1;
    @(posedge clk); #1;
    if (!hold) io_start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      lv[c] = io_mem_valid;
      le[c] = io_mem_enable;
      ld[c] = io_done;
      lb[c] = io_busy;
      la[c] = io_mem_addr;
    end
    io_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Expected pattern of one sweep of n commands: commands in cycles 1..n,
  // io_done in cycle n+1, and idle in cycle n+2.
  task automatic check_sweep(input string tag, input logic op, input int base, input int n);
    for (int c = 1; c <= n + 2; c++) begin
      check($sformatf("%s_valid_c%0d", tag, c), 32'(lv[c]), (c <= n) ? 32'd1 : 32'd0);
      check($sformatf("%s_en_c%0d", tag, c), 32'(le[c]), (c <= n) ? 32'(op) : 32'd0);
      check($sformatf("%s_addr_c%0d", tag, c), la[c], (c <= n) ? 32'((base + c - 1) % 8) : 32'd0);
      check($sformatf("%s_done_c%0d", tag, c), 32'(ld[c]), (c == n + 1) ? 32'd1 : 32'd0);
      check($sformatf("%s_busy_c%0d", tag, c), 32'(lb[c]), (c <= n + 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int nvalid;
    reset    = 1'b1;
    io_start = 1'b0;
    io_op    = 1'b0;
    io_base  = 3'd0;
    io_len   = 4'd0;
    mem_load = 1'b0;

    // Reset state.
    #12;
    check("rst_valid", 32'(io_mem_valid), 32'd0);
    check("rst_enable", 32'(io_mem_enable), 32'd0);
    check("rst_addr", io_mem_addr, 32'd0);
    check("rst_busy", 32'(io_busy), 32'd0);
    check("rst_done", 32'(io_done), 32'd0);
    check("rst_sum", io_sum, 32'd0);
    check("rst_last", io_last, 32'd0);
    reset = 1'b0;

    // INC full sweep over the data 0..7.
    preload(0, 1, 2, 3, 4, 5, 6, 7);
    run_sweep(1'b1, 3'd0, 4'd8, 10, 1'b0);
    check_sweep("inc8", 1'b1, 0, 8);
    check("inc8_sum", io_sum, SUM_EN ? 32'd28 : 32'd0);
    check("inc8_last", io_last, 32'd7);
    for (int i = 0; i < 8; i++) check($sformatf("inc8_mem%0d", i), mem[i], 32'(i + 1));

    // COPY wrapping sweep, base 6 and len 4. The data read is 7,8,1,2.
    run_sweep(1'b0, 3'd6, 4'd4, 6, 1'b0);
    check_sweep("copy4", 1'b0, 6, 4);
    check("copy4_sum", io_sum, SUM_EN ? 32'd18 : 32'd0);
    check("copy4_last", io_last, 32'd2);
    check("copy4_mem6", mem[6], 32'd3);
    check("copy4_mem7", mem[7], 32'd4);
    check("copy4_mem0", mem[0], 32'd5);
    check("copy4_mem1", mem[1], 32'd6);
    check("copy4_mem2", mem[2], 32'd3);

    // Empty sweep. It produces io_done and io_busy for one cycle, clears
    // io_sum and keeps io_last.
    run_sweep(1'b1, 3'd5, 4'd0, 3, 1'b0);
    check_sweep("empty", 1'b1, 5, 0);
    check("empty_sum", io_sum, 32'd0);
    check("empty_last", io_last, 32'd2);

    // A length of 12 is clamped to 8 commands.
    run_sweep(1'b0, 3'd3, 4'd12, 11, 1'b0);
    check_sweep("clamp", 1'b0, 3, 8);

    // With io_start held high, sweeps of 2 commands repeat with a period of 4 cycles.
    run_sweep(1'b1, 3'd0, 4'd2, 10, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("hold_valid_c%0d", c), 32'(lv[c]), (c % 4 == 1 || c % 4 == 2) ? 32'd1 : 32'd0);
      check($sformatf("hold_addr_c%0d", c), la[c], (c % 4 == 2) ? 32'd1 : 32'd0);
      check($sformatf("hold_done_c%0d", c), 32'(ld[c]), (c % 4 == 3) ? 32'd1 : 32'd0);
      check($sformatf("hold_busy_c%0d", c), 32'(lb[c]), (c % 4 != 0) ? 32'd1 : 32'd0);
    end

    // Assert reset while command idx 2 is presented.
    preload(0, 1, 2, 3, 4, 5, 6, 7);
    io_op = 1'b1; io_base = 3'd0; io_len = 4'd8; io_start = 1'b1;
    @(posedge clk); #1;
    io_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_valid", 32'(io_mem_valid), 32'd1);
    check("abort_pre_addr", io_mem_addr, 32'd2);
    #2 reset = 1'b1;
    #1;
    check("abort_valid", 32'(io_mem_valid), 32'd0);
    check("abort_enable", 32'(io_mem_enable), 32'd0);
    check("abort_addr", io_mem_addr, 32'd0);
    check("abort_busy", 32'(io_busy), 32'd0);
    check("abort_sum", io_sum, 32'd0);
    check("abort_last", io_last, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (io_mem_valid || io_busy) nvalid++;
    end
    check("abort_no_more_cmds", 32'(nvalid), 32'd0);
    run_sweep(1'b1, 3'd4, 4'd2, 4, 1'b0);
    check_sweep("after_abort", 1'b1, 4, 2);

    // INC sweep over the data 5,9,11. io_last is 11 in both builds; io_sum
    // depends on the build.
    preload(5, 9, 11, 0, 0, 0, 0, 0);
    run_sweep(1'b1, 3'd0, 4'd3, 5, 1'b0);
    check_sweep("data3", 1'b1, 0, 3);
    check("data3_last", io_last, 32'd11);
    check("data3_sum", io_sum, SUM_EN ? 32'd25 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rmw_sweep_driver
